// File: rtl/display_pkg.sv
// Shared seven-segment constants for the display path.
// All glyphs are active-low {g,f,e,d,c,b,a}.
package display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;

   // Entry k is the glyph for decimal digit k.
   localparam logic [9:0][6:0] DIGIT_GLYPH = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment glyph; nibbles 10-15 render as 'E'.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   always_comb begin
      if (i_nibble > 4'd9) o_seg = SEG_E;
      else                 o_seg = DIGIT_GLYPH[i_nibble];
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed BCD display driver with frame-aligned commit,
// leading-zero blanking and sign placement.
module bcd_display_scan
   import display_pkg::*;
#(
   parameter int unsigned DIGITS      = 8,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   bcd,
   input  logic                  neg,
   input  logic                  load,
   input  logic                  blank_en,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  err
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = $clog2(DIGITS);

   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [4*DIGITS-1:0]   r_pend_bcd;
   logic                  r_pend_neg;
   logic                  r_pend_valid;
   logic [4*DIGITS-1:0]   r_act_bcd;
   logic                  r_act_neg;
   logic                  r_act_blank;
   logic [DIGITS-1:0]     r_an;
   logic [6:0]            r_seg;
   logic                  r_err;

   logic                  w_tc;
   logic                  w_frame;
   logic [IW-1:0]         w_msd;
   logic                  w_inv;
   logic                  w_top_zero;
   logic [3:0]            w_nib;
   logic [6:0]            w_dec;
   logic [6:0]            w_glyph;
   logic                  w_err;
   logic                  w_above;
   logic                  w_next;

   assign w_tc    = (r_cnt == CW'(REFRESH_DIV - 1));
   assign w_frame = w_tc && (r_idx == IW'(DIGITS - 1));

   // msd is the highest non-zero nibble; invalid nibbles count as non-zero.
   always_comb begin
      w_msd = '0;
      w_inv = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_act_bcd[4*k +: 4] != 4'd0) w_msd = IW'(k);
         if (r_act_bcd[4*k +: 4] > 4'd9)  w_inv = 1'b1;
      end
   end

   assign w_top_zero = (r_act_bcd[4*DIGITS-1 -: 4] == 4'd0);
   assign w_nib      = r_act_bcd[4*r_idx +: 4];
   assign w_above    = (r_idx > w_msd);
   assign w_next     = ((IW+1)'(r_idx) == ((IW+1)'(w_msd) + (IW+1)'(1)));

   seg7_decode u_decode (
      .i_nibble (w_nib),
      .o_seg    (w_dec)
   );

   always_comb begin
      w_glyph = w_dec;
      if (w_nib <= 4'd9) begin
         if (r_act_blank && w_above) begin
            w_glyph = (r_act_neg && w_next) ? SEG_MINUS : SEG_BLANK;
         end else if (!r_act_blank && r_act_neg && (r_idx == IW'(DIGITS - 1)) && w_top_zero) begin
            w_glyph = SEG_MINUS;
         end
      end
   end

   assign w_err = w_inv |
                  (r_act_neg & ((w_msd == IW'(DIGITS - 1)) | (!r_act_blank & !w_top_zero)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_pend_bcd   <= '0;
         r_pend_neg   <= 1'b0;
         r_pend_valid <= 1'b0;
         r_act_bcd    <= '0;
         r_act_neg    <= 1'b0;
         r_act_blank  <= 1'b0;
         r_an         <= '1;
         r_seg        <= SEG_BLANK;
         r_err        <= 1'b0;
      end else begin
         r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
         if (w_tc) r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

         // A load landing on the boundary bypasses pending entirely.
         if (load && w_frame) begin
            r_act_bcd    <= bcd;
            r_act_neg    <= neg;
            r_act_blank  <= blank_en;
            r_pend_valid <= 1'b0;
         end else if (load) begin
            r_pend_bcd   <= bcd;
            r_pend_neg   <= neg;
            r_pend_valid <= 1'b1;
         end else if (w_frame && r_pend_valid) begin
            r_act_bcd    <= r_pend_bcd;
            r_act_neg    <= r_pend_neg;
            r_act_blank  <= blank_en;
            r_pend_valid <= 1'b0;
         end

         r_an  <= ~(DIGITS'(1) << r_idx);
         r_seg <= w_glyph;
         r_err <= w_err;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign err = r_err;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench: directed scenarios plus random loads against a text-level display model.
module tb_bcd_display_scan;

   localparam int D  = 4;
   localparam int RD = 4;
   localparam int FRAME = D * RD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd = '0;
   logic        neg = 1'b0;
   logic        load = 1'b0;
   logic        blank_en = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;
   int e        = 0;
   logic be     = 1'b0;

   logic [15:0] m_pend_bcd, m_act_bcd;
   logic        m_pend_neg, m_pend_valid, m_act_neg, m_act_blank;

   bcd_display_scan #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
      .clk      (clk),
      .rst      (rst),
      .bcd      (bcd),
      .neg      (neg),
      .load     (load),
      .blank_en (blank_en),
      .an       (an),
      .seg      (seg),
      .err      (err)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] digit_glyph(input int v);
      case (v)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h06;
      endcase
   endfunction

   // Render position k of the display from the number's digits.
   function automatic logic [6:0] exp_glyph(input logic [15:0] b, input logic n,
                                            input logic bl, input int k);
      int d[4];
      int top = 0;
      for (int i = 0; i < 4; i++) begin
         d[i] = int'(b[4*i +: 4]);
         if (d[i] != 0) top = i;
      end
      if (d[k] > 9) return 7'h06;
      if (bl) begin
         if (k <= top) return digit_glyph(d[k]);
         if (n && k == top + 1) return 7'h3F;
         return 7'h7F;
      end
      if (n && k == 3 && d[3] == 0) return 7'h3F;
      return digit_glyph(d[k]);
   endfunction

   function automatic logic exp_err(input logic [15:0] b, input logic n);
      logic inv = 1'b0;
      for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) inv = 1'b1;
      return inv | (n && b[15:12] != 4'd0);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend_bcd = '0; m_pend_neg = 1'b0; m_pend_valid = 1'b0;
      m_act_bcd  = '0; m_act_neg  = 1'b0; m_act_blank  = 1'b0;
      e = 0;
   endtask

   task automatic step(input logic ld, input logic [15:0] b, input logic n);
      int k;
      logic [3:0] x_an;
      logic [6:0] x_seg;
      logic x_err;
      bit bnd;
      load = ld; bcd = b; neg = n; blank_en = be;
      @(posedge clk);
      k     = (e / RD) % D;
      x_an  = ~(4'(1) << k);
      x_seg = exp_glyph(m_act_bcd, m_act_neg, m_act_blank, k);
      x_err = exp_err(m_act_bcd, m_act_neg);
      bnd   = (e % FRAME) == FRAME - 1;
      if (ld && bnd) begin
         m_act_bcd = b; m_act_neg = n; m_act_blank = be; m_pend_valid = 1'b0;
      end else if (ld) begin
         m_pend_bcd = b; m_pend_neg = n; m_pend_valid = 1'b1;
      end else if (bnd && m_pend_valid) begin
         m_act_bcd = m_pend_bcd; m_act_neg = m_pend_neg; m_act_blank = be; m_pend_valid = 1'b0;
      end
      e++;
      #1;
      load = 1'b0;
      chk("an", {4'b0, an}, {4'b0, x_an});
      chk("seg", {1'b0, seg}, {1'b0, x_seg});
      chk("err", {7'b0, err}, {7'b0, x_err});
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 16'h0, 1'b0);
   endtask

   task automatic idle_to(input int phase);
      while ((e % FRAME) != phase) step(1'b0, 16'h0, 1'b0);
   endtask

   initial begin
      logic [15:0] rb;
      logic        rn;
      int          zt;

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", {4'b0, an}, 8'h0F);
      chk("rst_seg", {1'b0, seg}, 8'h7F);
      chk("rst_err", {7'b0, err}, 8'h00);
      rst = 1'b0;

      idle(24);

      be = 1'b1;
      step(1'b1, 16'h1234, 1'b0); idle(36);
      step(1'b1, 16'h0042, 1'b1); idle(36);
      step(1'b1, 16'h9000, 1'b1); idle(36);
      step(1'b1, 16'h00A5, 1'b0); idle(36);

      // Collision: last load lands exactly on the frame boundary.
      idle_to(7);  step(1'b1, 16'h1111, 1'b0);
      idle_to(15); step(1'b1, 16'h2222, 1'b0);
      idle(20);
      idle_to(13); step(1'b1, 16'h5678, 1'b0);
      idle(20);

      be = 1'b0;
      step(1'b1, 16'h0000, 1'b1); idle(36);
      step(1'b1, 16'h0305, 1'b1); idle(36);
      step(1'b1, 16'h4000, 1'b1); idle(20);
      be = 1'b1;
      step(1'b1, 16'h0000, 1'b1); idle(36);
      // Unloaded frame must not pick up the new blank_en.
      be = 1'b0;
      idle(36);

      // Asynchronous reset between edges with a pending load.
      idle_to(3);
      step(1'b1, 16'h3333, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_an", {4'b0, an}, 8'h0F);
      chk("arst_seg", {1'b0, seg}, 8'h7F);
      chk("arst_err", {7'b0, err}, 8'h00);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      be = 1'b1;
      idle(40);

      for (int it = 0; it < 25; it++) begin
         rb = '0;
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) rb[4*i +: 4] = 4'($urandom_range(10, 15));
            else                           rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         zt = $urandom_range(0, 4);
         for (int i = 0; i < 4; i++) if (i >= 4 - zt) rb[4*i +: 4] = 4'h0;
         rn = 1'($urandom_range(0, 1));
         be = 1'($urandom_range(0, 1));
         step(1'b1, rb, rn);
         idle($urandom_range(0, 24));
      end
      idle(FRAME + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Downstream of the output unit's binary-to-BCD converter, this block drives a time-multiplexed common-anode seven-segment display.
- Captures a packed BCD word and a sign bit on a load strobe.
- Commits the captured value only at frame boundaries, so a frame never mixes old and new values.
- Applies leading-zero blanking and places a minus sign to the left of the most significant digit.
- Scans one digit at a time at a programmable refresh rate.

## Interface
- DIGITS, 8, number of display digits; legal range ≥2.
- REFRESH_DIV, 50000, clocks each digit stays lit; legal range ≥1.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- bcd  input  4*DIGITS  packed BCD value; digit k is bcd[4k+3:4k], digit 0 is least significant.
- neg  input  1  value is negative.
- load  input  1  single-cycle strobe that captures bcd and neg into the pending register.
- blank_en  input  1  enables leading-zero suppression; sampled at commit.
- an  output  DIGITS  digit enables, active-low one-hot.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- err  output  1  active value contains an invalid nibble, or the sign cannot be shown.

## Operation
- Registers:
  - pending: bcd, neg, pend_valid.
  - active: bcd, neg, blank.
  - prescaler cnt: 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV) with a minimum of 1.
  - digit index idx: 0..DIGITS-1.
- Prescaler: cnt increments every clock. At terminal count it wraps to 0 and idx advances.
- idx wraps from DIGITS-1 to 0. That wrap is the frame boundary.
- Load: `load=1` writes pending and sets pend_valid. A later load before commit overwrites pending; the last value wins.
- Commit happens at the frame boundary when pend_valid is set:
  - pending is copied to active;
  - blank_en is sampled into active;
  - pend_valid is cleared.
- Load and frame boundary in the same cycle: the new bcd/neg bypass pending straight into active, and pend_valid ends cleared.
- msd: index of the highest non-zero digit of active; 0 if all digits are zero.
- Per-digit glyph for digit k, first matching rule wins:
  1. Nibble > 9: 'E' (0x06).
  2. blank set, k > msd, neg set, and k == msd+1: '-' (0x3F).
  3. blank set and k > msd: blank (0x7F).
  4. Otherwise: decoded digit.
- With blank clear, a negative value shows '-' in place of the top digit. This applies only when the top digit is zero; otherwise the sign is not shown.
- err = (any active nibble > 9) OR (neg AND the minus glyph has no legal position, i.e. msd == DIGITS-1, or blank clear and top digit non-zero).
- Digit 0 is never blanked. A value of zero shows a single '0'. Negative zero shows "-0".
- Digit encodings: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.

## Timing
- While rst is asserted, every register clears:
  - cnt=0, idx=0;
  - pending and active bcd=0, neg=0, blank=0, pend_valid=0;
  - an=all ones, seg=0x7F, err=0.
- an, seg and err are registered. Each clock they reflect the idx, active state and cnt of the previous cycle.
  - First clock after reset release: an=~1, seg=0x40.
- Digit dwell is exactly REFRESH_DIV clocks. Frame period is DIGITS*REFRESH_DIV clocks.
- REFRESH_DIV=1: idx advances every clock.
- Load-to-display latency:
  - The value appears on the clock after the next frame boundary.
  - Worst case is DIGITS*REFRESH_DIV+1 clocks.
- rst asserted mid-frame or with a pending load: the pending value is discarded. The display returns to its reset state asynchronously.
- blank_en changes take effect only at a commit; an unloaded frame does not update blank.

## Structure
- Shared package `display_pkg`:
  - constants SEG_BLANK=7'h7F, SEG_MINUS=7'h3F, SEG_E=7'h06;
  - a 10-entry digit glyph table.
- One sub-module, `seg7_decode`: combinational, 4-bit nibble in, 7-bit active-low segments out, 'E' for nibbles 10–15. It is instantiated once and fed by the nibble that idx selects.
- Leading-zero detection (msd) lives in the top level, computed from active.bcd.

## Test plan
Bench parameters: DIGITS=4, REFRESH_DIV=4.

- **Reset:** assert rst for 3 clocks, release. an=4'b1110, seg=0x40, err=0; an=4'b1101 after 4 more clocks.
- **Basic scan:** load bcd=16'h1234, neg=0, blank_en=1. After the next boundary one frame shows, in order, digits 0..3 = 0x19, 0x30, 0x24, 0x79, each for 4 clocks.
- **Blanking and sign:** load 16'h0042, neg=1, blank_en=1. Digit 3=0x7F, digit 2=0x3F, digit 1=0x19, digit 0=0x24, err=0.
- **Sign overflow and invalid nibble:**
  - load 16'h9000, neg=1: '-' not shown, err=1.
  - load 16'h00A5: digit 1=0x06, err=1.
- **Load/boundary collision:**
  - load 16'h1111 mid-frame, then 16'h2222 in the boundary cycle: the next frame shows 2222.
  - A load issued two clocks before the boundary is displayed starting the clock after the boundary.
- **Async reset mid-operation:** assert rst between clock edges while pend_valid=1. Outputs go to an=4'hF, seg=0x7F without waiting for an edge, and the pending value is never displayed.
